param_priority_queue_encoder: RTL
=================================

Name: param_priority_queue_encoder

Overview:
Parametrised, registered successor to the team's 8-to-3 priority encoder. It latches requests into a sticky pending vector and issues one encoded index per grant through a valid/ready handshake. Each bit is cleared from pending when its index is issued. The block is used wherever several sources raise events and a downstream consumer drains them one index at a time, possibly with backpressure.

Parameters:
WIDTH, 8, number of request lines (≥2)
IDX_W, $clog2(WIDTH), width of encoded index output

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Enable  input  1  when 1, Req_In is sampled into pending; when 0, Req_In is ignored
Req_In  input  WIDTH  request vector; bit i requests index i
Out  output  IDX_W  issued index, registered
Out_Valid  output  1  Out holds an issued index
Out_Ready  input  1  consumer accepts Out this cycle
Pending  output  WIDTH  registered pending vector (not yet issued)
Valid_Bit  output  1  |Pending | Out_Valid, registered-derived

Behaviour:
- Reset is asynchronous and active-low. While Reset_n=0: Pending=0, Out=0, Out_Valid=0, Valid_Bit=0. Any in-flight index is discarded. The RR pointer resets to WIDTH-1.
- Pending update at each edge: Pending <= (Pending & ~load_mask) | (Enable ? Req_In : 0).
  - Set wins over clear. A bit re-requested in its own load cycle stays pending.
  - Repeat requests on an already-pending bit merge. They are not counted.
- The selector operates on the registered Pending only. It chooses the highest set index (bit WIDTH-1 has top priority). load_mask is one-hot of the selected bit.
- Two states:
  - IDLE (Out_Valid=0): if Pending≠0, load Out=sel and clear that bit; the next state is PRESENT. Otherwise stay in IDLE.
  - PRESENT (Out_Valid=1):
    - Out_Ready=0: hold Out stable. No load occurs and Pending still accumulates.
    - Out_Ready=1 and Pending≠0: load the next sel in the same edge (back-to-back, one index per cycle) and stay in PRESENT.
    - Out_Ready=1 and Pending=0: Out_Valid goes to 0 and the state returns to IDLE. Out keeps its last value.
- Latency: a request sampled at edge k appears as Out_Valid=1 after edge k+1 at the earliest. There is no combinational path from Req_In or Out_Ready to any output.
- Enable=0 does not stall draining. Pending and Out continue to issue and handshake normally.
- Req_In=0 with Pending=0: outputs stay idle, and Valid_Bit=0 once Out is accepted.
- WIDTH that is not a power of two: indices ≥WIDTH are never produced.

Optional Feature:
Macro ROUND_ROBIN_EN.
- Defined: rotating priority. The search starts at pointer Ptr and goes downward with wrap-around. After each load of index i, Ptr <= (i==0) ? WIDTH-1 : i-1, which makes i the lowest priority next time. Ptr resets to WIDTH-1.
- Undefined: fixed MSB-first priority. No pointer register exists.

Decomposition:
- Package prio_enc_pkg: state enum (IDLE, PRESENT) and a function clog2_min1 so that IDX_W≥1.
- Sub-module prio_select: purely combinational. Inputs are the vector and a rotation offset (tied to WIDTH-1 when the feature is off). Outputs are the index and an any-set flag. It is instantiated once.

Test Plan:
1. Reset, then Enable=1, Req_In=8'b0010_0100 for one cycle, Out_Ready=1 → Out=5 valid, next cycle Out=2 valid, next cycle Out_Valid=0, Valid_Bit=0.
2. Out_Ready=0, Req_In=8'b1000_0001 pulsed → Out=7 held with Out_Valid=1 for 5 cycles, Pending=8'b0000_0001. Raise Out_Ready → next cycle Out=0, then idle.
3. Enable=0, Req_In=8'hFF for 4 cycles → Pending=0, Out_Valid=0, Valid_Bit=0 throughout.
4. Pending=8'b0000_1000 in IDLE with Req_In=8'b0000_1000 on the load edge, Out_Ready=1 → Out=3, then Out=3 again, then idle.
5. Pending=8'hF0 and Out_Valid=1; drive Reset_n low between edges → Pending, Out, Out_Valid, Valid_Bit go to 0 immediately. After release, Req_In=8'h02 → Out=1.
6. Req_In=8'b1000_0001 held with Out_Ready=1 → with ROUND_ROBIN_EN the sequence is 7,0,7,0…; without it the sequence is 7,7,7… and index 0 is never issued.

Source files
------------

// File: rtl/param_priority_queue_encoder_pkg.sv
// prio_enc_pkg: shared state encoding and index-width helper for the priority queue encoder.
package prio_enc_pkg;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_e;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/param_priority_queue_encoder_if.sv
// param_priority_queue_encoder_if: request/issue bus between producers, encoder and consumer.
interface param_priority_queue_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = prio_enc_pkg::clog2_min1(WIDTH)
);
  logic             Enable;
  logic [WIDTH-1:0] Req_In;
  logic [IDX_W-1:0] Out;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Pending;
  logic             Valid_Bit;
  modport master (output Enable, Req_In, Out_Ready, input Out, Out_Valid, Pending, Valid_Bit);
  modport slave  (input Enable, Req_In, Out_Ready, output Out, Out_Valid, Pending, Valid_Bit);
endinterface

// File: rtl/param_priority_queue_encoder_prio_select.sv
// prio_select: picks the set bit closest below-or-at off_i, searching downward with wrap-around.
module prio_select #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [IDX_W-1:0] off_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  int d, best;
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    best  = WIDTH;
    d     = 0;
    // distance 0 is off_i itself, growing as the search walks downward and wraps
    for (int i = 0; i < WIDTH; i++) begin
      d = (int'(off_i) + WIDTH - i) % WIDTH;
      if (vec_i[i] && d < best) begin
        best  = d;
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/param_priority_queue_encoder.sv
// param_priority_queue_encoder: sticky pending requests drained one index per valid/ready handshake.
// Define ROUND_ROBIN_EN for rotating priority; otherwise fixed MSB-first.
module param_priority_queue_encoder
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = clog2_min1(WIDTH)
) (
  input logic Clk,
  input logic Reset_n,
  param_priority_queue_encoder_if.slave bus
);
  localparam logic [0:0] IDLE    = ST_IDLE;
  localparam logic [0:0] PRESENT = ST_PRESENT;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d, load_mask;
  logic [IDX_W-1:0] out_q, out_d, sel, ptr;
  logic             any, load;
  prio_select #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_sel (
    .vec_i(pending_q),
    .off_i(ptr),
    .idx_o(sel),
    .any_o(any)
  );
  always_comb begin
    load      = any && (state_q == IDLE || bus.Out_Ready);
    load_mask = load ? WIDTH'(1) << sel : '0;
    // set after clear, so a re-request in its own load cycle stays pending
    pending_d = (pending_q & ~load_mask) | (bus.Enable ? bus.Req_In : '0);
    out_d     = load ? sel : out_q;
    state_d   = load ? PRESENT : bus.Out_Ready ? IDLE : state_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end
`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  // the index just issued becomes lowest priority for the next search
  always_comb ptr_d = !load ? ptr_q : (sel == '0) ? IDX_W'(WIDTH - 1) : sel - IDX_W'(1);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) ptr_q <= IDX_W'(WIDTH - 1);
    else          ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
`else
  assign ptr = IDX_W'(WIDTH - 1);
`endif
  assign bus.Out       = out_q;
  assign bus.Out_Valid = (state_q == PRESENT);
  assign bus.Pending   = pending_q;
  assign bus.Valid_Bit = (|pending_q) | (state_q == PRESENT);
endmodule
